pip_skid_stage: RTL
===================

PIP_SKID_STAGE -- requirements
Module: pip_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning datapath payload width (e.g. ALU result plus store data).
REQ-002 SHALL have parameter CTRL_W, default 22, meaning control payload width (register addresses, memory enables, memory control, write-back enables).
REQ-003 SHALL have parameter ZERO_BUBBLE, default 1, meaning that when it is 1, empty entries hold all-zero data and control.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, which is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, meaning the upstream beat is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the stage accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, DATA_W, meaning the upstream datapath payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W, meaning the upstream control payload.
REQ-010 SHALL have port discard, input, 1, meaning flush all held beats and drop any incoming beat.
REQ-011 SHALL have port out_valid, output, 1, meaning the downstream beat is valid.
REQ-012 SHALL have port out_ready, input, 1, meaning downstream accepts the beat.
REQ-013 SHALL have port out_data, output, DATA_W, meaning the downstream datapath payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W, meaning the downstream control payload.
REQ-015 SHALL have port occupancy, output, 2, meaning the number of held beats (0..2).

Function
REQ-016 SHALL hold two entries: MAIN (drives out_*) and SKID (overflow); states EMPTY (0 held), ONE (MAIN only), FULL (MAIN+SKID); occupancy encodes the state directly.
REQ-017 SHALL register in_ready as !SKID.valid — no combinational path from out_ready to in_ready.
REQ-018 SHALL count a beat as accepted when in_valid & in_ready & !discard, and as consumed when out_valid & out_ready.
REQ-019 SHALL apply these state transitions when discard=0: EMPTY+accept->ONE; ONE+accept+!consume->FULL; ONE+accept+consume->ONE with MAIN loaded from input; ONE+!accept+consume->EMPTY; FULL+consume->ONE with MAIN loaded from SKID; all other cases hold state.
REQ-020 SHALL never accept in FULL; the FULL state always drives in_ready=0 the same cycle.
REQ-021 SHALL have latency of 1 cycle from accept to out_valid when MAIN is empty or is being consumed; otherwise the beat waits in SKID.
REQ-022 SHALL preserve order, with no duplication and no loss of accepted beats absent discard.
REQ-023 SHALL keep out_data/out_ctrl stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when discard=1, go to EMPTY next cycle regardless of other inputs, drop the same-cycle input beat, and leave the same-cycle handshake on the output irrelevant; in_ready=1 the following cycle.
REQ-025 SHALL, when ZERO_BUBBLE=1, clear an entry's data and control to 0 whenever the entry becomes empty (consume, discard, reset), so downstream sees zero control (no memory write, no register write) on bubbles.
REQ-026 SHALL, when ZERO_BUBBLE=0, leave the payload of empty entries don't-care; out_valid alone qualifies it.
REQ-027 SHALL support arbitrary DATA_W>=1 and CTRL_W>=1, with payloads moved as opaque bit vectors.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set the state to EMPTY, out_valid=0, occupancy=0, in_ready=1, and out_data=0 and out_ctrl=0 (regardless of ZERO_BUBBLE).
REQ-029 SHALL give rst priority over discard and handshakes; rst mid-transfer drops both entries.

Verification
REQ-030 SHALL cover streaming: out_ready=1 held, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, occupancy=1, in_ready stays 1.
REQ-031 SHALL cover backpressure: out_ready=0 after beat A is held, then beat B is sent -> occupancy=2 and in_ready=0 next cycle; out_ready=1 -> A then B in order, and in_ready returns to 1.
REQ-032 SHALL cover discard while FULL: discard=1 with in_valid=1 carrying C -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and C never appears.
REQ-033 SHALL cover simultaneous accept and consume in ONE: MAIN=X, out_ready=1, in_valid=1 with Y -> next cycle out_data=Y and occupancy=1.
REQ-034 SHALL cover reset mid-operation: FULL, then rst=1 for 1 cycle -> occupancy=0, in_ready=1, out_data=0; a subsequent beat emerges normally.
REQ-035 SHALL cover parameter sweeps: DATA_W=1/CTRL_W=1 and DATA_W=128/CTRL_W=40 pass REQ-030..034; random valid/ready traffic with a scoreboard shows zero mismatches over 10k cycles.

Source files
------------

// File: rtl/pip_skid_stage.sv
// Two-entry pipeline skid stage: MAIN drives the outputs, SKID absorbs one beat
// of backpressure so in_ready can be a flop instead of a path from out_ready.
module pip_skid_stage #(
  parameter int DATA_W      = 64,
  parameter int CTRL_W      = 22,
  parameter bit ZERO_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              discard,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_accept;
  logic w_consume;

  assign w_accept  = in_valid & r_in_ready & ~discard;
  assign w_consume = r_out_valid & out_ready;

  // NOTE: every register here, payload included, gets <= so all of them
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload is reset too, so out_data/out_ctrl read zero after reset
      // even when ZERO_BUBBLE=0.
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (discard) begin
      r_state     <= S_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      if (ZERO_BUBBLE) begin
        r_main_data <= '0;
        r_main_ctrl <= '0;
        r_skid_data <= '0;
        r_skid_ctrl <= '0;
      end
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end
        end
        S_ONE: begin
          if (w_accept && !w_consume) begin
            // MAIN is stalled, so the new beat parks in SKID and input closes.
            r_state     <= S_FULL;
            r_in_ready  <= 1'b0;
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
          end else if (w_accept) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
          end else if (w_consume) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            if (ZERO_BUBBLE) begin
              r_main_data <= '0;
              r_main_ctrl <= '0;
            end
          end
        end
        S_FULL: begin
          if (w_consume) begin
            r_state     <= S_ONE;
            r_in_ready  <= 1'b1;
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            if (ZERO_BUBBLE) begin
              r_skid_data <= '0;
              r_skid_ctrl <= '0;
            end
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;
  assign occupancy = r_state;

endmodule
